// File: rtl/bram_port_ctrl.sv
// rtl/bram_port_ctrl.sv - CPU bus to byte-masked synchronous BRAM port controller
//
// Bridges a valid/ready CPU request bus onto a single-port 32-bit BRAM with
// four byte lanes and a one-cycle registered read. Requests outside the
// address window are ignored. Optionally zero-fills the BRAM after reset.
//
// Ports:
//   clk         clock, all logic on the rising edge
//   resetn      asynchronous active-low reset
//   cpu_valid   request valid, held with addr/wdata/wstrb until cpu_ready
//   cpu_addr    byte address (bits [1:0] ignored)
//   cpu_wdata   write data
//   cpu_wstrb   byte strobes, 0 = read
//   cpu_ready   registered one-cycle completion pulse
//   cpu_rdata   registered read data, valid with cpu_ready after a read
//   init_done   high once the post-reset clear has finished
//   bram_addr   BRAM word address
//   bram_wdata  BRAM write data
//   bram_wmask  BRAM byte write enables
//   bram_rdata  BRAM read data, valid the cycle after bram_addr

module bram_port_ctrl #(
  parameter int          WIDTH          = 8,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter bit          CLEAR_ON_RESET = 1'b0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             cpu_valid,
  input  logic [31:0]      cpu_addr,
  input  logic [31:0]      cpu_wdata,
  input  logic [3:0]       cpu_wstrb,
  output logic             cpu_ready,
  output logic [31:0]      cpu_rdata,
  output logic             init_done,
  output logic [WIDTH-1:0] bram_addr,
  output logic [31:0]      bram_wdata,
  output logic [3:0]       bram_wmask,
  input  logic [31:0]      bram_rdata
);

  typedef enum logic [1:0] {
    CLEAR   = 2'd0,
    IDLE    = 2'd1,
    RD_WAIT = 2'd2,
    ACK     = 2'd3
  } state_t;

  localparam state_t RESET_STATE = CLEAR_ON_RESET ? CLEAR : IDLE;

  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] clr_cnt;
  logic             clr_last;
  logic             hit;
  logic [WIDTH-1:0] word_addr;
  logic             unused_addr_bits;

  assign hit              = cpu_valid && (cpu_addr[31:WIDTH+2] == BASE_ADDR[31:WIDTH+2]);
  assign word_addr        = cpu_addr[WIDTH+1:2];
  assign clr_last         = (clr_cnt == {WIDTH{1'b1}});
  assign unused_addr_bits = ^cpu_addr[1:0];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= RESET_STATE;
      clr_cnt   <= {WIDTH{1'b0}};
      cpu_ready <= 1'b0;
      cpu_rdata <= 32'h0;
      init_done <= !CLEAR_ON_RESET;
    end else begin
      state <= state_n;
      // Ready is registered from the next state so it is high exactly in ACK.
      cpu_ready <= (state_n == ACK);
      if (state == CLEAR) begin
        clr_cnt <= clr_cnt + 1'b1;
        if (clr_last) begin
          init_done <= 1'b1;
        end
      end
      // BRAM data for the address presented in IDLE is valid during RD_WAIT.
      if (state == RD_WAIT) begin
        cpu_rdata <= bram_rdata;
      end
    end
  end

  always_comb begin
    state_n    = state;
    bram_addr  = word_addr;
    bram_wdata = cpu_wdata;
    bram_wmask = 4'h0;
    case (state)
      CLEAR: begin
        bram_addr  = clr_cnt;
        bram_wdata = 32'h0;
        bram_wmask = 4'hF;
        if (clr_last) begin
          state_n = IDLE;
        end
      end
      IDLE: begin
        if (hit) begin
          if (cpu_wstrb != 4'h0) begin
            // Write commits at the end of this cycle only.
            bram_wmask = cpu_wstrb;
            state_n    = ACK;
          end else begin
            state_n = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        state_n = ACK;
      end
      ACK: begin
        // The CPU still holds the finished request here, so it must not be
        // decoded again.
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule
